// File: rtl/nn_argmax_classifier.sv
// Sequential argmax over the 10 class scores of vfr_nn, with a winner/score result
// handshake and saturating total/correct counters for measuring accuracy in hardware.
module nn_argmax_classifier #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*WIDTH-1:0]   net_outputs,
    input  logic [3:0]            exp_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            class_idx,
    output logic [WIDTH-1:0]      max_val,
    output logic                  match,
    input  logic                  clear_stats,
    output logic [CNT_W-1:0]      total_cnt,
    output logic [CNT_W-1:0]      correct_cnt
);

    localparam int unsigned NUM_LANES = 10;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned VEC_W     = NUM_LANES * WIDTH;
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX  = {CNT_W{1'b1}};

    // The comparison does not depend on the fixed-point split; only sanity-check it.
    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [VEC_W-1:0]         vec_q;
    logic [IDX_W-1:0]         exp_q;
    logic [IDX_W-1:0]         lane_q;
    logic [IDX_W-1:0]         run_idx_q;
    logic signed [WIDTH-1:0]  run_max_q;
    logic signed [WIDTH-1:0]  lane_val;
    logic                     accept_c;
    logic                     finish_c;
    logic                     better_c;
    logic                     match_c;

    // Lane counter runs 1..10 for compares; value 11 is the register cycle into DONE.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        finish_c = 1'b0;
        in_ready = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (lane_q == IDX_W'(NUM_LANES + 1)) begin
                    finish_c = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured vector shifts down one lane per cycle so lane k is always at the bottom.
    assign lane_val = vec_q[WIDTH-1:0];
    assign better_c = (lane_val > run_max_q);
    assign match_c  = (exp_q != '0) && (run_idx_q == exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q     <= '0;
            exp_q     <= '0;
            lane_q    <= '0;
            run_idx_q <= '0;
            run_max_q <= '0;
        end else if (accept_c) begin
            vec_q     <= net_outputs;
            exp_q     <= exp_idx;
            lane_q    <= IDX_W'(1);
            run_idx_q <= IDX_W'(1);
            run_max_q <= MOST_NEG;
        end else if (state_q == S_SCAN && !finish_c) begin
            if (better_c) begin
                run_max_q <= lane_val;
                run_idx_q <= lane_q;
            end
            vec_q  <= vec_q >> WIDTH;
            lane_q <= lane_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            match     <= 1'b0;
        end else if (finish_c) begin
            out_valid <= 1'b1;
            class_idx <= run_idx_q;
            max_val   <= run_max_q;
            match     <= match_c;
        end else if (state_q == S_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics count labeled vectors only; a clear overrides a coincident update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
        end else if (clear_stats) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
        end else if (finish_c && exp_q != '0) begin
            if (total_cnt != CNT_MAX) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (match_c && correct_cnt != CNT_MAX) begin
                correct_cnt <= correct_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Bench for nn_argmax_classifier: directed vector table, hold/reset/saturation sequences,
// and randomized vectors against an argmax reference model.
module tb_nn_argmax_classifier;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = 3;
    localparam int          NT = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [10*WIDTH-1:0]  net_outputs;
    logic [3:0]           exp_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           class_idx;
    logic [WIDTH-1:0]     max_val;
    logic                 match;
    logic                 clear_stats;
    logic [CNT_W-1:0]     total_cnt;
    logic [CNT_W-1:0]     correct_cnt;

    nn_argmax_classifier #(.WIDTH(WIDTH), .FRAC(8), .CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .net_outputs (net_outputs),
        .exp_idx     (exp_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .max_val     (max_val),
        .match       (match),
        .clear_stats (clear_stats),
        .total_cnt   (total_cnt),
        .correct_cnt (correct_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*WIDTH-1:0] lanes;
        logic [3:0]          exp_in;
        logic [3:0]          idx;
        logic [WIDTH-1:0]    maxv;
        logic                m;
    } vec_t;

    vec_t                tbl [NT];
    logic [10*WIDTH-1:0] cur_vec;
    int                  checks = 0;
    int                  failures = 0;
    int                  m_total = 0;
    int                  m_correct = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: find the largest signed score, then the first lane holding it.
    task automatic ref_argmax(input logic [3:0] e, output logic [3:0] idx,
                              output logic [WIDTH-1:0] mx, output logic m);
        logic signed [WIDTH-1:0] best;
        logic signed [WIDTH-1:0] v;
        bit found;
        best = cur_vec[WIDTH-1:0];
        for (int k = 1; k < 10; k++) begin
            v = cur_vec[k*WIDTH +: WIDTH];
            if (v > best) best = v;
        end
        found = 0;
        idx = 4'd1;
        for (int k = 0; k < 10; k++) begin
            if (!found && $signed(cur_vec[k*WIDTH +: WIDTH]) == best) begin
                idx = 4'(k + 1);
                found = 1;
            end
        end
        mx = best;
        m = (e != 0) && (idx == e);
    endtask

    task automatic model_stats(input logic [3:0] e, input logic m, input bit clr);
        if (clr) begin
            m_total = 0;
            m_correct = 0;
        end else if (e != 0) begin
            if (m_total < CNT_MAX) m_total++;
            if (m && m_correct < CNT_MAX) m_correct++;
        end
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL %s in_ready timeout actual=0 required=1", nm);
        end
    endtask

    // Full transaction: accept, measure latency, check result/stats, handshake.
    task automatic run_vec(input string nm, input logic [3:0] e, input logic [3:0] xi,
                           input logic [WIDTH-1:0] xm, input logic xmatch, input bit clr_done);
        int lat;
        wait_ready(nm);
        in_valid    = 1'b1;
        net_outputs = cur_vec;
        exp_idx     = e;
        tick();
        in_valid    = 1'b0;
        net_outputs = {$urandom, $urandom, $urandom, $urandom, $urandom};
        exp_idx     = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 30) begin
            if (lat == 10 && clr_done) clear_stats = 1'b1;
            tick();
            lat++;
            clear_stats = 1'b0;
            if (lat == 5) chk({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
        end
        chk({nm, " latency"}, 32'(lat), 32'd11);
        model_stats(e, xmatch, clr_done);
        chk({nm, " class_idx"}, 32'(class_idx), 32'(xi));
        chk({nm, " max_val"}, 32'(max_val), 32'(xm));
        chk({nm, " match"}, 32'(match), 32'(xmatch));
        chk({nm, " total_cnt"}, 32'(total_cnt), 32'(m_total));
        chk({nm, " correct_cnt"}, 32'(correct_cnt), 32'(m_correct));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]       ri;
        logic [WIDTH-1:0] rm;
        logic             rmatch;
        logic [3:0]       re;
        int               seen;

        // Directed vector table.
        for (int k = 0; k < 10; k++) begin
            tbl[0].lanes[k*WIDTH +: WIDTH] = 16'(16 * (k + 1));
            tbl[1].lanes[k*WIDTH +: WIDTH] = (k == 2 || k == 6) ? 16'h0200 : 16'h0100;
            tbl[2].lanes[k*WIDTH +: WIDTH] = (k == 4) ? 16'h8000 : 16'hFF00;
            tbl[3].lanes[k*WIDTH +: WIDTH] = 16'h8000;
            tbl[4].lanes[k*WIDTH +: WIDTH] = (k == 8) ? 16'hFFFF : (k == 3) ? 16'hFFFE : 16'h8000;
            tbl[5].lanes[k*WIDTH +: WIDTH] = (k == 0) ? 16'h7FFF : 16'h0000;
            tbl[6].lanes[k*WIDTH +: WIDTH] = (k == 9) ? 16'h0001 : 16'h8000;
        end
        tbl[0].exp_in = 4'd10; tbl[0].idx = 4'd10; tbl[0].maxv = 16'h00A0; tbl[0].m = 1'b1;
        tbl[1].exp_in = 4'd7;  tbl[1].idx = 4'd3;  tbl[1].maxv = 16'h0200; tbl[1].m = 1'b0;
        tbl[2].exp_in = 4'd1;  tbl[2].idx = 4'd1;  tbl[2].maxv = 16'hFF00; tbl[2].m = 1'b1;
        tbl[3].exp_in = 4'd1;  tbl[3].idx = 4'd1;  tbl[3].maxv = 16'h8000; tbl[3].m = 1'b1;
        tbl[4].exp_in = 4'd12; tbl[4].idx = 4'd9;  tbl[4].maxv = 16'hFFFF; tbl[4].m = 1'b0;
        tbl[5].exp_in = 4'd0;  tbl[5].idx = 4'd1;  tbl[5].maxv = 16'h7FFF; tbl[5].m = 1'b0;
        tbl[6].exp_in = 4'd10; tbl[6].idx = 4'd10; tbl[6].maxv = 16'h0001; tbl[6].m = 1'b1;

        rst = 1'b1;
        in_valid = 1'b0;
        net_outputs = '0;
        exp_idx = '0;
        out_ready = 1'b0;
        clear_stats = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset class_idx", 32'(class_idx), 32'd0);
        chk("reset max_val", 32'(max_val), 32'd0);
        chk("reset match", 32'(match), 32'd0);
        chk("reset total_cnt", 32'(total_cnt), 32'd0);
        chk("reset correct_cnt", 32'(correct_cnt), 32'd0);

        for (int i = 0; i < NT; i++) begin
            cur_vec = tbl[i].lanes;
            run_vec($sformatf("tbl%0d", i), tbl[i].exp_in, tbl[i].idx, tbl[i].maxv, tbl[i].m, 1'b0);
        end

        // Consumer stalls 20 clocks while the source keeps changing its inputs.
        cur_vec = tbl[1].lanes;
        wait_ready("stall");
        in_valid = 1'b1;
        net_outputs = cur_vec;
        exp_idx = 4'd3;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 30) begin
            tick();
            seen++;
        end
        model_stats(4'd3, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            net_outputs = {$urandom, $urandom, $urandom, $urandom, $urandom};
            exp_idx = 4'($urandom);
            tick();
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall class_idx", 32'(class_idx), 32'd3);
            chk("stall max_val", 32'(max_val), 32'h0200);
        end
        chk("stall match", 32'(match), 32'd1);
        chk("stall total_cnt", 32'(total_cnt), 32'(m_total));
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall release in_ready", 32'(in_ready), 32'd1);
        chk("stall release out_valid", 32'(out_valid), 32'd0);
        cur_vec = tbl[0].lanes;
        run_vec("post_stall", 4'd10, 4'd10, 16'h00A0, 1'b1, 1'b0);

        // Reset four clocks into SCAN aborts the vector.
        cur_vec = tbl[0].lanes;
        wait_ready("rst_abort");
        in_valid = 1'b1;
        net_outputs = cur_vec;
        exp_idx = 4'd10;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort class_idx", 32'(class_idx), 32'd0);
        chk("abort max_val", 32'(max_val), 32'd0);
        chk("abort total_cnt", 32'(total_cnt), 32'd0);
        chk("abort correct_cnt", 32'(correct_cnt), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        m_total = 0;
        m_correct = 0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort no out_valid", 32'(seen), 32'd0);
        cur_vec = tbl[5].lanes;
        run_vec("unlabeled", 4'd0, 4'd1, 16'h7FFF, 1'b0, 1'b0);

        // Counters saturate, then a clear coinciding with SCAN->DONE wins.
        cur_vec = tbl[0].lanes;
        for (int n = 0; n < 5; n++) begin
            run_vec($sformatf("sat%0d", n), 4'd10, 4'd10, 16'h00A0, 1'b1, 1'b0);
        end
        chk("sat total_cnt", 32'(total_cnt), 32'd3);
        chk("sat correct_cnt", 32'(correct_cnt), 32'd3);
        run_vec("clear_at_done", 4'd10, 4'd10, 16'h00A0, 1'b1, 1'b1);

        // Randomized vectors against the reference model.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 10; k++) begin
                case (mode)
                    0:       cur_vec[k*WIDTH +: WIDTH] = 16'($urandom);
                    1:       cur_vec[k*WIDTH +: WIDTH] = 16'($urandom_range(0, 3));
                    default: cur_vec[k*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
                endcase
            end
            re = 4'($urandom_range(0, 12));
            ref_argmax(re, ri, rm, rmatch);
            run_vec($sformatf("rand%0d", n), re, ri, rm, rmatch, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                clear_stats = 1'b1;
                tick();
                clear_stats = 1'b0;
                model_stats(4'd0, 1'b0, 1'b1);
                chk("idle clear total_cnt", 32'(total_cnt), 32'd0);
                chk("idle clear correct_cnt", 32'(correct_cnt), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
